// File: rtl/enc_arbiter.sv
// Round-robin front end that time-shares one encoder lookup between NREQ clients.
// Define ENC_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module enc_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 4,
  parameter int SETTLE = 1,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  enc_rst,
  output logic [WIDTH-1:0]      enc_data_in,
  input  logic [WIDTH-1:0]      enc_data_out
);

  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IDW-1:0]    id_reg, id_next;
  logic [WIDTH-1:0]  enc_data_in_reg, enc_data_in_next;
  logic [WIDTH-1:0]  rsp_data_reg, rsp_data_next;
  logic              enc_rst_reg;

  logic [IDW-1:0]    base;
  logic [IDW-1:0]    cand_idx [NREQ];
  logic [NREQ-1:0]   cand_valid;
  logic [WIDTH-1:0]  req_word [NREQ];
  logic [IDW-1:0]    win_idx;
  logic              win_found;
  logic              grant;

`ifdef ENC_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IDW-1:0] rr_ptr_reg;

  // Pointer moves only when a response completes, so a stalled client keeps its turn order.
  always_ff @(posedge clk) begin
    if (!rst)
      rr_ptr_reg <= '0;
    else if (state_reg == RESP && rsp_ready)
      rr_ptr_reg <= (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
  end

  assign base = rr_ptr_reg;
`endif

  // Slot gi holds the requester that sits gi places after the current pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      logic [IDW:0] sum;
      assign sum = {1'b0, base} + (IDW+1)'(gi);
      assign cand_idx[gi]   = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : IDW'(sum);
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
      assign req_word[gi]   = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_valid[k])
        win_idx = cand_idx[k];
    end
  end

  assign win_found = |req_valid;
  assign grant     = rst && (state_reg == IDLE) && win_found;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    id_next          = id_reg;
    enc_data_in_next = enc_data_in_reg;
    rsp_data_next    = rsp_data_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next       = ISSUE;
          enc_data_in_next = req_word[win_idx];
          id_next          = win_idx;
          cnt_next         = CW'(SETTLE - 1);
        end
      end
      ISSUE: begin
        if (cnt_reg == '0) begin
          rsp_data_next = enc_data_out;
          state_next    = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      id_reg          <= '0;
      enc_data_in_reg <= '0;
      rsp_data_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      id_reg          <= id_next;
      enc_data_in_reg <= enc_data_in_next;
      rsp_data_reg    <= rsp_data_next;
    end
  end

  // Encoder leaves reset on the same edge that the first grant can be taken.
  always_ff @(posedge clk) begin
    enc_rst_reg <= ~rst;
  end

  assign rsp_valid   = (state_reg == RESP);
  assign rsp_id      = id_reg;
  assign rsp_data    = rsp_data_reg;
  assign enc_rst     = enc_rst_reg;
  assign enc_data_in = enc_data_in_reg;

endmodule

// File: tb/tb_enc_arbiter.sv
// Bench for enc_arbiter: two instances (SETTLE=1 and SETTLE=3), each with a negedge encoder model.
module tb_enc_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  rsp_ready;
  logic                  sel;

  logic [NREQ-1:0]  req_valid1, req_ready1, req_valid3, req_ready3;
  logic             rsp_valid1, rsp_valid3, enc_rst1, enc_rst3;
  logic [1:0]       rsp_id1, rsp_id3;
  logic [WIDTH-1:0] rsp_data1, rsp_data3, enc_in1, enc_in3, enc_out1, enc_out3;

  assign req_valid1 = sel ? '0 : req_valid;
  assign req_valid3 = sel ? req_valid : '0;

  enc_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
    .enc_rst(enc_rst1), .enc_data_in(enc_in1), .enc_data_out(enc_out1));

  enc_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_data(req_data), .req_ready(req_ready3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_id(rsp_id3), .rsp_data(rsp_data3),
    .enc_rst(enc_rst3), .enc_data_in(enc_in3), .enc_data_out(enc_out3));

  // Encoder stand-in: known lookup points plus an arbitrary mixing function elsewhere.
  function automatic logic [31:0] enc_fn(input logic [31:0] d);
    case (d)
      32'd0:    return 32'd1423;
      32'd123:  return 32'hFFFFFA70;
      32'd7000: return 32'hFFFFF05F;
      32'd1023: return 32'hFF807017;
      32'd5:    return 32'h0;
      default:  return {d[7:0], d[31:8]} ^ 32'h5A5AC3C3;
    endcase
  endfunction

  always @(negedge clk) begin
    enc_out1 <= enc_rst1 ? '0 : enc_fn(enc_in1);
    enc_out3 <= enc_rst3 ? '0 : enc_fn(enc_in3);
  end

  logic [NREQ-1:0]  o_req_ready;
  logic             o_rsp_valid;
  logic [1:0]       o_rsp_id;
  logic [WIDTH-1:0] o_rsp_data, o_enc_in;
  assign o_req_ready = sel ? req_ready3 : req_ready1;
  assign o_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign o_rsp_id    = sel ? rsp_id3    : rsp_id1;
  assign o_rsp_data  = sel ? rsp_data3  : rsp_data1;
  assign o_enc_in    = sel ? enc_in3    : enc_in1;

  int checks = 0;
  int errors = 0;
  int ptr1 = 0;
  int ptr3 = 0;

  function automatic int model_pick(input logic [NREQ-1:0] mask, input int ptr);
`ifdef ENC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (mask[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (mask[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic int model_next_ptr(input int w);
`ifdef ENC_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (w + 1) % NREQ;
`endif
  endfunction

  // Drives one request through grant, optional stall in RESP, and handshake; reports observations.
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data,
                         input int stall, output int gnt, output int lat,
                         output logic [1:0] id, output logic [31:0] rd, output logic [31:0] ed,
                         output bit to, output bit stab);
    int n;
    gnt = -1; lat = 0; id = '0; rd = '0; ed = '0; to = 1'b0; stab = 1'b1;
    @(posedge clk); #1;
    req_valid = mask; req_data = data; rsp_ready = 1'b0;
    n = 0; #3;
    while (o_req_ready == '0 && n < 10) begin @(posedge clk); #4; n++; end
    if (o_req_ready == '0) begin to = 1'b1; req_valid = '0; return; end
    for (int i = 0; i < NREQ; i++) if (o_req_ready == (4'b0001 << i)) gnt = i;
    @(posedge clk); #1;
    req_valid = '0;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    lat = 1; #3;
    ed = o_enc_in;
    while (!o_rsp_valid && lat < 40) begin @(posedge clk); #4; lat++; end
    if (!o_rsp_valid) begin to = 1'b1; return; end
    id = o_rsp_id; rd = o_rsp_data;
    for (int s = 0; s < stall; s++) begin
      req_valid = mask; #1;
      if (o_req_ready != '0 || !o_rsp_valid || o_rsp_id !== id || o_rsp_data !== rd) stab = 1'b0;
      @(posedge clk); #4;
    end
    if (o_req_ready != '0 || !o_rsp_valid || o_rsp_id !== id || o_rsp_data !== rd) stab = 1'b0;
    req_valid = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'hF; req_data = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #4;
      checks++;
      if (rsp_valid1 !== 1'b0 || enc_in1 !== '0 || enc_rst1 !== 1'b1 || req_ready1 !== '0 ||
          rsp_id1 !== '0 || rsp_data1 !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: rsp_valid=%b enc_in=%h enc_rst=%b req_ready=%b id=%0d data=%h, required 0/0/1/0/0/0",
                 c, rsp_valid1, enc_in1, enc_rst1, req_ready1, rsp_id1, rsp_data1);
      end
      checks++;
      if (rsp_valid3 !== 1'b0 || enc_rst3 !== 1'b1 || req_ready3 !== '0) begin
        errors++;
        $display("FAIL reset_state3[%0d]: rsp_valid=%b enc_rst=%b req_ready=%b", c, rsp_valid3, enc_rst3, req_ready3);
      end
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    ptr1 = 0; ptr3 = 0;
    @(posedge clk); #4;
    checks++;
    if (enc_rst1 !== 1'b0) begin
      errors++;
      $display("FAIL enc_rst_release: got %b required 0", enc_rst1);
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    int gnt, lat; logic [1:0] id; logic [31:0] rd, ed; bit to, stab;
    run_txn(4'b0010, '0, 0, gnt, lat, id, rd, ed, to, stab);
    checks++;
    if (to || gnt != 1 || lat != 2 || id !== 2'd1 || rd !== 32'd1423) begin
      errors++;
      $display("FAIL single: to=%0b gnt=%0d lat=%0d id=%0d data=%h, required gnt=1 lat=2 id=1 data=%h",
               to, gnt, lat, id, rd, 32'd1423);
    end
    ptr1 = model_next_ptr(1);
    $display("single: gnt=%0d lat=%0d id=%0d data=%h", gnt, lat, id, rd);
  endtask

  task automatic test_lookup();
    logic [31:0] ins [4];
    logic [31:0] exps [4];
    int gnt, lat; logic [1:0] id; logic [31:0] rd, ed; bit to, stab;
    ins  = '{32'd123, 32'd7000, 32'd1023, 32'd5};
    exps = '{32'hFFFFFA70, 32'hFFFFF05F, 32'hFF807017, 32'h0};
    for (int t = 0; t < 4; t++) begin
      logic [NREQ*WIDTH-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[31:0] = ins[t];
      run_txn(4'b0001, d, 0, gnt, lat, id, rd, ed, to, stab);
      checks++;
      if (to || gnt != 0 || id !== 2'd0 || rd !== exps[t] || ed !== ins[t]) begin
        errors++;
        $display("FAIL lookup[%0d]: to=%0b gnt=%0d id=%0d data=%h enc_in=%h, required gnt=0 data=%h enc_in=%h",
                 t, to, gnt, id, rd, ed, exps[t], ins[t]);
      end
      ptr1 = model_next_ptr(0);
      $display("lookup: in=%0d data=%h", ins[t], rd);
    end
  endtask

  task automatic test_random(input int n, input int max_stall);
    int gnt, lat, w; logic [1:0] id; logic [31:0] rd, ed, ew; bit to, stab;
    logic [NREQ-1:0] mask; logic [NREQ*WIDTH-1:0] d;
    for (int t = 0; t < n; t++) begin
      mask = 4'($urandom_range(1, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      w = model_pick(mask, ptr1);
      ew = d[w*WIDTH +: WIDTH];
      run_txn(mask, d, $urandom_range(0, max_stall), gnt, lat, id, rd, ed, to, stab);
      checks++;
      if (to || gnt != w || lat != 2 || id !== 2'(w) || rd !== enc_fn(ew) || ed !== ew || !stab) begin
        errors++;
        $display("FAIL random[%0d]: mask=%b to=%0b gnt=%0d lat=%0d id=%0d data=%h stable=%0b, required gnt=%0d lat=2 data=%h",
                 t, mask, to, gnt, lat, id, rd, stab, w, enc_fn(ew));
      end
      ptr1 = model_next_ptr(w);
      $display("random: mask=%b gnt=%0d data=%h", mask, gnt, rd);
    end
  endtask

  task automatic test_backpressure();
    int gnt, lat, w; logic [1:0] id; logic [31:0] rd, ed, ew; bit to, stab;
    logic [NREQ-1:0] mask; logic [NREQ*WIDTH-1:0] d;
    for (int t = 0; t < 2; t++) begin
      mask = 4'($urandom_range(1, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      w = model_pick(mask, ptr1);
      ew = d[w*WIDTH +: WIDTH];
      run_txn(mask, d, 5, gnt, lat, id, rd, ed, to, stab);
      checks++;
      if (to || !stab || gnt != w || rd !== enc_fn(ew)) begin
        errors++;
        $display("FAIL backpressure[%0d]: to=%0b stable=%0b gnt=%0d data=%h, required stable=1 gnt=%0d data=%h",
                 t, to, stab, gnt, rd, w, enc_fn(ew));
      end
      ptr1 = model_next_ptr(w);
      $display("backpressure: gnt=%0d stable=%0b", gnt, stab);
    end
  endtask

  task automatic test_reset_midflight();
    int gnt, lat; logic [1:0] id; logic [31:0] rd, ed; bit to, stab;
    run_txn(4'b0100, {$urandom, $urandom, $urandom, $urandom}, 0, gnt, lat, id, rd, ed, to, stab);
    ptr1 = model_next_ptr(2);
    @(posedge clk); #1;
    req_valid = 4'b0100; #3;
    checks++;
    if (req_ready1 !== 4'b0100) begin
      errors++;
      $display("FAIL midflight_grant: got %b required 0100", req_ready1);
    end
    @(posedge clk); #1;
    req_valid = '0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; ptr1 = 0;
    for (int c = 0; c < 5; c++) begin
      #3;
      checks++;
      if (rsp_valid1 !== 1'b0 || rsp_data1 !== '0) begin
        errors++;
        $display("FAIL midflight_norsp[%0d]: rsp_valid=%b data=%h required 0/0", c, rsp_valid1, rsp_data1);
      end
      @(posedge clk); #1;
    end
    run_txn(4'hF, {$urandom, $urandom, $urandom, $urandom}, 0, gnt, lat, id, rd, ed, to, stab);
    checks++;
    if (to || gnt != 0) begin
      errors++;
      $display("FAIL midflight_regrant: to=%0b gnt=%0d required 0", to, gnt);
    end
    ptr1 = model_next_ptr(0);
    $display("reset_midflight: regrant=%0d", gnt);
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    int gnt, lat; logic [1:0] id; logic [31:0] rd, ed; bit to, stab;
`ifdef ENC_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    ptr1 = 0; ptr3 = 0;
    for (int t = 0; t < 5; t++) begin
      run_txn(4'hF, {$urandom, $urandom, $urandom, $urandom}, 0, gnt, lat, id, rd, ed, to, stab);
      checks++;
      if (to || gnt != exp_order[t] || gnt != model_pick(4'hF, ptr1) || id !== 2'(exp_order[t])) begin
        errors++;
        $display("FAIL round_robin[%0d]: to=%0b gnt=%0d id=%0d required %0d", t, to, gnt, id, exp_order[t]);
      end
      ptr1 = model_next_ptr(exp_order[t]);
      $display("round_robin: gnt=%0d", gnt);
    end
  endtask

  task automatic test_settle();
    int gnt, lat, w; logic [1:0] id; logic [31:0] rd, ed, ew; bit to, stab;
    logic [NREQ-1:0] mask; logic [NREQ*WIDTH-1:0] d;
    sel = 1'b1;
    for (int t = 0; t < 3; t++) begin
      mask = 4'($urandom_range(1, 15));
      d = {$urandom, $urandom, $urandom, $urandom};
      w = model_pick(mask, ptr3);
      ew = d[w*WIDTH +: WIDTH];
      run_txn(mask, d, 0, gnt, lat, id, rd, ed, to, stab);
      checks++;
      if (to || lat != 4 || gnt != w || id !== 2'(w) || rd !== enc_fn(ew)) begin
        errors++;
        $display("FAIL settle3[%0d]: to=%0b lat=%0d gnt=%0d data=%h, required lat=4 gnt=%0d data=%h",
                 t, to, lat, gnt, rd, w, enc_fn(ew));
      end
      ptr3 = model_next_ptr(w);
      $display("settle3: gnt=%0d lat=%0d data=%h", gnt, lat, rd);
    end
    sel = 1'b0;
  endtask

  initial begin
    sel = 1'b0; rst = 1'b0; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_lookup();
    test_random(20, 2);
    test_backpressure();
    test_reset_midflight();
    test_round_robin();
    test_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/enc_arbiter.md
# enc_arbiter

Round-robin arbiter and sequencer that shares a single `encoder` lookup instance between `NREQ` requesters. It accepts one request at a time over a valid/ready handshake and drives the encoder's `data_in`. It waits for the encoder's negedge-registered result, then returns the result with the requester ID over a valid/ready response port. It sits between client blocks and one `encoder` instance, which it also holds in reset.

## Interface
- `WIDTH`, 32: data width; must match the encoder's `WIDTH`.
- `NREQ`, 4: number of requesters, 2..8.
- `SETTLE`, 1: cycles spent in ISSUE before capture, 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WIDTH  flattened; slice i = `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  clog2(NREQ)  index of the served requester.
- `rsp_data`  out  WIDTH  encoder result.
- `enc_rst`  out  1  active-high reset to the encoder, registered `~rst`.
- `enc_data_in`  out  WIDTH  registered operand driven to the encoder.
- `enc_data_out`  in  WIDTH  encoder result; it updates on the falling edge of `clk`.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE transition:
  - If any `req_valid` is set, pick winner w = the first set bit searching upward from `rr_ptr` with wrap-around.
  - `req_ready[w]` is asserted combinationally in that cycle only.
  - Latch `enc_data_in <= req_data[w]` and `id <= w`.
  - Load settle counter = `SETTLE`-1, then go to ISSUE.
- ISSUE: `enc_data_in` is held stable. The counter decrements each cycle. On the cycle the counter is 0, capture `rsp_data <= enc_data_out` and go to RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_id` and `rsp_data` held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE and set `rr_ptr <= (w+1) mod NREQ`.
- `req_ready` is 0 in ISSUE and in RESP. Only one transaction is in flight at a time.
- `req_valid` may drop before it is granted; this is allowed and no grant is issued for it.
- Requesters must hold `req_data` stable only in the grant cycle.
- `rr_ptr` updates only on response completion, never on grant.
- Reset values (while `rst`=0):
  - state = IDLE, `rr_ptr` = 0, `enc_data_in` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `req_ready` = 0.
  - `enc_rst` = 1 on the next edge.
- Reset asserted mid-transaction (in ISSUE or RESP): the transaction is dropped, no response is produced, and all registers return to their reset values on that edge.
- The first grant is allowed in the first cycle with `rst`=1. `enc_rst` deasserts at that same edge, so the encoder is out of reset before its first negedge sample.

## Timing
- With `SETTLE`=1, a request granted in cycle N:
  - `enc_data_in` is valid from N+1.
  - The encoder samples it at the negedge inside N+1.
  - `rsp_data` is captured at the end of N+1.
  - `rsp_valid`=1 in N+2.
- Latency from grant to `rsp_valid` is 1+`SETTLE` cycles.
- Best-case throughput is one transaction per 2+`SETTLE` cycles. The IDLE cycle is mandatory, so there is no back-to-back grant.
- `rsp_valid` never drops without a handshake, except on reset.

## Configuration
- `ENC_ARB_FIXED_PRIO_EN`:
  - Defined: the winner is the lowest-index requester with `req_valid` set. `rr_ptr` is not implemented and reads as 0.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset and single request:
  - `rst`=0 for 3 cycles: `rsp_valid`=0, `enc_data_in`=0, `enc_rst`=1.
  - Release `rst`, then requester 1 sends `req_data`=0 → `rsp_valid` 2 cycles after grant, `rsp_id`=1, `rsp_data`=32'd1423.
- Lookup values: requester 0 sends 123, 7000, 1023 and 5 in sequence → `rsp_data` = 32'hFFFFFA70, 32'hFFFFF05F, 32'hFF807017, 32'h0.
- Round-robin:
  - All 4 requesters hold `req_valid` continuously → grant order 0,1,2,3,0.
  - With `ENC_ARB_FIXED_PRIO_EN` defined → always 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_data` stay stable, and every `req_ready` stays 0 throughout.
- Reset mid-flight: assert `rst`=0 during ISSUE → no response, and the first grant after release goes to requester 0.
- Settle: `SETTLE`=3 → `rsp_valid` appears 4 cycles after grant, with the correct `rsp_data`.
